block_scheduler: RTL and testbench
==================================

BLOCK_SCHEDULER -- requirements
Module: block_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles a grant is held without done (legal range 1..65535).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the hold counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port blocks, input, 7 bits: per-block present/enable mask; bit i=0 makes block i ineligible.
REQ-006 SHALL have port req, input, 7 bits: per-block service request, level-sensitive.
REQ-007 SHALL have port done, input, 1 bit: the granted block finished; sampled only in GRANT.
REQ-008 SHALL have port grant, output, 7 bits: one-hot grant, or all zero.
REQ-009 SHALL have port selector, output, 3 bits: index of the granted block; 3'd7 (SEL_NONE) when no grant.
REQ-010 SHALL have port busy, output, 1 bit: high whenever grant is nonzero.
REQ-011 SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is revoked by the hold counter.

Function
REQ-012 SHALL implement states IDLE, GRANT and RELEASE.
REQ-013 SHALL define eligible = req & blocks.
REQ-014 IDLE: if eligible≠0, SHALL move to GRANT next edge with grant/selector registered from the round-robin winner (request-to-grant latency 1 cycle); otherwise stay in IDLE.
REQ-015 Round-robin winner SHALL be the first eligible index searching ptr+1, ptr+2, … modulo 7 (6 wraps to 0); ptr = last granted index.
REQ-016 On entering GRANT, SHALL update ptr to the winner and clear the hold counter to 0.
REQ-017 In GRANT, hold counter SHALL increment by 1 per cycle, saturating at TIMEOUT.
REQ-018 GRANT SHALL exit to RELEASE when any of the following holds for the granted index: done=1, req bit=0, blocks bit=0, or counter=TIMEOUT-1.
REQ-019 If done=1 and the counter expires in the same cycle, done SHALL win and timeout SHALL stay 0.
REQ-020 If GRANT exits on counter expiry alone, timeout SHALL pulse high for exactly the first cycle of RELEASE.
REQ-021 RELEASE SHALL last exactly 1 cycle with grant=0, selector=SEL_NONE and busy=0, then go to IDLE.
REQ-022 The minimum gap between consecutive grants SHALL therefore be 2 cycles (RELEASE, IDLE).
REQ-023 grant, selector and busy SHALL be registered outputs, mutually consistent every cycle.
REQ-024 selector SHALL equal the bit position of the one-hot grant.
REQ-025 Changes on req or blocks while in GRANT SHALL NOT change the winner; only the exit conditions of REQ-018 apply.

Reset
REQ-026 reset_n=0 SHALL asynchronously force: state=IDLE, grant=0, selector=3'd7, busy=0, timeout=0, counter=0, ptr=6 (so the first search starts at index 0).
REQ-027 Reset asserted mid-GRANT SHALL drop grant immediately, with no timeout pulse.
REQ-028 Operation after reset release SHALL resume from the REQ-026 values.

Structure
REQ-029 The shared package SHALL hold the state enumeration, NUM_BLOCKS=7 and SEL_NONE=3'd7.
REQ-030 The rotated priority search SHALL be a combinational sub-module rr_pick (inputs eligible, ptr; outputs valid, idx).
REQ-031 State register, counter and output registers SHALL reside in block_scheduler.

Verification
REQ-032 Reset release, blocks=7'h7F, req=7'h01 -> grant=7'h01, selector=0 one cycle later; done pulse -> RELEASE cycle with grant=0, then IDLE.
REQ-033 req=7'h7F held, done pulsed one cycle after each grant -> selector sequence 0,1,2,3,4,5,6,0 (wrap), with 2 idle cycles between grants.
REQ-034 blocks=7'h7E, req=7'h03 -> only block 1 is granted; block 0 is never granted.
REQ-035 TIMEOUT=4, req=7'h08 held, no done -> grant held 4 cycles, then timeout=1 for one cycle, then block 3 is re-granted.
REQ-036 done and expiry in the same cycle -> timeout stays 0; reset_n low mid-GRANT -> grant=0 and selector=7 in the same cycle.

Source files
------------

// File: rtl/block_scheduler_pkg.sv
// Shared types and constants for the seven-block round-robin scheduler.
package block_scheduler_pkg;

  localparam int NUM_BLOCKS = 7;
  localparam int SEL_W      = 3;

  // Selector value reported while no block holds the grant.
  localparam logic [SEL_W-1:0] SEL_NONE = 3'd7;

  // Pointer value at reset, so the first search starts at block 0.
  localparam logic [SEL_W-1:0] PTR_INIT = 3'd6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/block_scheduler_rr_pick.sv
// Rotated priority search: the first eligible block after ptr, wrapping modulo NUM_BLOCKS.
module rr_pick
  import block_scheduler_pkg::*;
(
  input  logic [NUM_BLOCKS-1:0] eligible,
  input  logic [SEL_W-1:0]      ptr,
  output logic                  valid,
  output logic [SEL_W-1:0]      idx
);

  always_comb begin
    // NOTE: combinational outputs get a default before the loop so no path leaves them unassigned (no latch).
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_BLOCKS; k++) begin
      int cand;
      cand = (int'(ptr) + k) % NUM_BLOCKS;
      if (!valid && eligible[cand]) begin
        valid = 1'b1;
        idx   = SEL_W'(cand);
      end
    end
  end

endmodule

// File: rtl/block_scheduler.sv
// Round-robin grant scheduler: one block at a time, bounded hold time, one release cycle between grants.
module block_scheduler
  import block_scheduler_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_BLOCKS-1:0] blocks,
  input  logic [NUM_BLOCKS-1:0] req,
  input  logic                  done,
  output logic [NUM_BLOCKS-1:0] grant,
  output logic [SEL_W-1:0]      selector,
  output logic                  busy,
  output logic                  timeout
);

  state_e           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  logic [NUM_BLOCKS-1:0] eligible;
  logic                  pick_valid;
  logic [SEL_W-1:0]      pick_idx;

  logic still_wanted;
  logic expired;
  logic leave_grant;
  logic expire_only;

  assign eligible = req & blocks;

  rr_pick u_rr_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  // Masking with the one-hot grant avoids indexing by selector, which is SEL_NONE outside GRANT.
  assign still_wanted = |(eligible & grant);
  assign expired      = (cnt == CNT_W'(TIMEOUT - 1));
  assign leave_grant  = done || !still_wanted || expired;
  // done has priority over expiry, so timeout only flags a revocation by the counter itself.
  assign expire_only  = expired && !done && still_wanted;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      grant    <= '0;
      selector <= SEL_NONE;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      cnt      <= '0;
      ptr      <= PTR_INIT;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees the pre-edge values of the others.
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= GRANT;
            grant    <= NUM_BLOCKS'(1) << pick_idx;
            selector <= pick_idx;
            busy     <= 1'b1;
            ptr      <= pick_idx;
            cnt      <= '0;
          end
        end
        GRANT: begin
          if (cnt != CNT_W'(TIMEOUT)) begin
            cnt <= cnt + 1'b1;
          end
          if (leave_grant) begin
            state    <= RELEASE;
            grant    <= '0;
            selector <= SEL_NONE;
            busy     <= 1'b0;
            timeout  <= expire_only;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          grant    <= '0;
          selector <= SEL_NONE;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_scheduler.sv
// Directed and randomized checks of block_scheduler against a cycle-level behavioural model.
module tb_block_scheduler;

  localparam int TIMEOUT = 4;

  logic       clk;
  logic       reset_n;
  logic [6:0] blocks;
  logic [6:0] req;
  logic       done;
  logic [6:0] grant;
  logic [2:0] selector;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // Model: currently granted block (-1 none), cycles it has been visible,
  // remaining blank cycles before a new search, last granted block, timeout flag.
  int   m_cur;
  int   m_held;
  int   m_gap;
  int   m_last;
  logic m_to;

  block_scheduler #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .blocks   (blocks),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .selector (selector),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_cur  = -1;
    m_held = 0;
    m_gap  = 0;
    m_last = 6;
    m_to   = 1'b0;
  endtask

  task automatic model_step(input logic [6:0] r, input logic [6:0] b, input logic d);
    int start;
    logic keep;
    m_to = 1'b0;
    if (m_cur >= 0) begin
      keep = r[m_cur] && b[m_cur];
      if (d || !keep || m_held == TIMEOUT) begin
        m_to  = !d && keep;
        m_cur = -1;
        m_gap = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      start = m_last;
      for (int k = 1; k <= 7; k++) begin
        int c;
        c = (start + k) % 7;
        if (m_cur < 0 && r[c] && b[c]) begin
          m_cur  = c;
          m_last = c;
          m_held = 1;
        end
      end
    end
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag);
    logic [6:0] eg;
    logic [2:0] es;
    logic       eb;
    eg = (m_cur < 0) ? 7'h00 : 7'(1 << m_cur);
    es = (m_cur < 0) ? 3'd7 : 3'(m_cur);
    eb = (m_cur >= 0);
    checks++;
    assert (grant === eg) else begin
      errors++;
      $error("FAIL %s grant: observed %h expected %h", tag, grant, eg);
    end
    checks++;
    assert (selector === es) else begin
      errors++;
      $error("FAIL %s selector: observed %0d expected %0d", tag, selector, es);
    end
    checks++;
    assert (busy === eb) else begin
      errors++;
      $error("FAIL %s busy: observed %b expected %b", tag, busy, eb);
    end
    checks++;
    assert (timeout === m_to) else begin
      errors++;
      $error("FAIL %s timeout: observed %b expected %b", tag, timeout, m_to);
    end
  endtask

  // Drive inputs away from the edge, let one rising edge pass, then compare.
  task automatic step(input logic [6:0] r, input logic [6:0] b, input logic d, input string tag);
    req    = r;
    blocks = b;
    done   = d;
    @(posedge clk);
    model_step(r, b, d);
    #1;
    compare(tag);
  endtask

  task automatic do_reset();
    req     = '0;
    blocks  = '0;
    done    = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare("reset");
    @(posedge clk);
    #1;
    compare("reset_hold");
    reset_n = 1'b1;
  endtask

  initial begin
    int         sels[$];
    int         gaps[$];
    int         idle_run;
    logic       prev_busy;
    logic [6:0] r;
    logic [6:0] b;
    logic [11:0] exp_busy;
    logic [11:0] exp_to;
    int         b0_seen;
    int         b1_seen;

    reset_n = 1'b1;
    req     = '0;
    blocks  = '0;
    done    = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Single request, done on the first grant cycle.
    step(7'h01, 7'h7F, 1'b0, "single_grant");
    check_val("single_grant_direct", int'(grant), 1);
    check_val("single_sel_direct", int'(selector), 0);
    step(7'h01, 7'h7F, 1'b1, "single_done");
    check_val("release_grant_zero", int'(grant), 0);
    check_val("release_sel_none", int'(selector), 7);
    step(7'h00, 7'h7F, 1'b0, "single_idle");
    step(7'h00, 7'h7F, 1'b0, "single_idle2");

    // All blocks requesting: full rotation with wrap and two blank cycles per gap.
    do_reset();
    prev_busy = 1'b0;
    idle_run  = 0;
    for (int i = 0; i < 40 && sels.size() < 8; i++) begin
      step(7'h7F, 7'h7F, (m_cur >= 0), "rotation");
      if (busy && !prev_busy) begin
        sels.push_back(int'(selector));
        if (sels.size() > 1) gaps.push_back(idle_run);
      end
      idle_run  = busy ? 0 : idle_run + 1;
      prev_busy = busy;
    end
    check_val("rotation_count", sels.size(), 8);
    for (int i = 0; i < sels.size(); i++) check_val("rotation_sel", sels[i], i % 7);
    for (int i = 0; i < gaps.size(); i++) check_val("rotation_gap", gaps[i], 2);

    // Disabled block 0 is never granted.
    do_reset();
    b0_seen = 0;
    b1_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(7'h03, 7'h7E, ($urandom_range(0, 1) == 0), "masked");
      if (grant[0]) b0_seen++;
      if (grant[1]) b1_seen++;
    end
    check_val("masked_block0_never", b0_seen, 0);
    check_val("masked_block1_granted", int'(b1_seen > 0), 1);

    // Hold until expiry: four grant cycles, a timeout pulse, one blank cycle, re-grant.
    do_reset();
    exp_busy = 12'b001111001111;
    exp_to   = 12'b010000010000;
    for (int i = 0; i < 12; i++) begin
      step(7'h08, 7'h7F, 1'b0, "expiry");
      check_val("expiry_busy_pattern", int'(busy), int'(exp_busy[i]));
      check_val("expiry_timeout_pattern", int'(timeout), int'(exp_to[i]));
    end

    // done arriving in the last counted cycle wins over expiry.
    do_reset();
    step(7'h08, 7'h7F, 1'b0, "race_grant");
    step(7'h08, 7'h7F, 1'b0, "race_hold1");
    step(7'h08, 7'h7F, 1'b0, "race_hold2");
    step(7'h08, 7'h7F, 1'b0, "race_hold3");
    step(7'h08, 7'h7F, 1'b1, "race_done");
    check_val("race_no_timeout", int'(timeout), 0);
    check_val("race_released", int'(busy), 0);

    // Reset asserted mid-grant drops everything without waiting for an edge.
    step(7'h00, 7'h7F, 1'b0, "pre_mid_reset");
    step(7'h10, 7'h7F, 1'b0, "pre_mid_reset2");
    check_val("mid_reset_granted", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_val("mid_reset_grant", int'(grant), 0);
    check_val("mid_reset_sel", int'(selector), 7);
    check_val("mid_reset_timeout", int'(timeout), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(7'h10, 7'h7F, 1'b0, "post_reset");

    // Randomized traffic, requests and masks changing occasionally.
    r = 7'($urandom);
    b = 7'($urandom) | 7'h41;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 7'($urandom);
      if ($urandom_range(0, 7) == 0) b = 7'($urandom);
      step(r, b, ($urandom_range(0, 3) == 0), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
